// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the in-order writeback package and the entry format
// of the writeback stage's pending divider-result queue.
package pipeline_pkg;

    localparam int XLEN          = 32;
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] rd_data;
        logic [4:0]      rd_addr;
        logic            wren;
        logic            valid;
    } pipe_buff_t;

    typedef struct packed {
        logic [XLEN-1:0] rd_data;
        logic [4:0]      rd_addr;
        logic            valid;
    } wb_entry_t;

    // True when a package really writes an architectural register (x0 never counts).
    function automatic logic writes_rd(input pipe_buff_t pkg);
        return pkg.valid & pkg.wren & (pkg.rd_addr != 5'd0);
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Writeback-stage bus: in-order and divider result packages in, register-file
// write port plus divider back-pressure and pending-register mask out.
interface wb_stage_if;
    import pipeline_pkg::*;

    pipe_buff_t      pipe_wb_pkg;
    pipe_buff_t      div_wb_pkg;
    logic            div_stall;
    logic            rf_wren;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     pend_mask;

    modport master (
        output pipe_wb_pkg, div_wb_pkg,
        input  div_stall, rf_wren, rf_waddr, rf_wdata, pend_mask
    );

    modport slave (
        input  pipe_wb_pkg, div_wb_pkg,
        output div_stall, rf_wren, rf_waddr, rf_wdata, pend_mask
    );

endinterface

// File: rtl/register.sv
// Shared enabled register with synchronous active-high reset.
module register #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_pend_fifo.sv
// Pending divider-result queue: in-order storage whose entries can be killed
// in place by a younger in-order write to the same register.
module wb_pend_fifo import pipeline_pkg::*; #(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  wb_entry_t   push_entry,
    input  logic        pop,
    input  logic        kill_en,
    input  logic [4:0]  kill_addr,
    output wb_entry_t   head,
    output logic        full,
    output logic        empty,
    output logic [31:0] pend_mask
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = entries[rd_ptr];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Killed and popped slots drop their valid bit so the mask only shows live targets.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && entries[i].valid && entries[i].rd_addr == kill_addr) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (pop_ok) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr                <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) begin
                pend_mask[entries[i].rd_addr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates the single register-file write port between the
// in-order pipe result and queued out-of-order divider completions.
module wb_stage import pipeline_pkg::*; #(
    parameter int DEPTH = WB_FIFO_DEPTH,
    parameter int XLEN  = pipeline_pkg::XLEN
) (
    input  logic      i_clk,
    input  logic      i_rst,
    wb_stage_if.slave bus
);

    pipe_buff_t      pipe_pkg;
    pipe_buff_t      div_pkg;
    logic            pipe_win;
    logic            div_ok;
    logic            div_killed;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    wb_entry_t       head;
    wb_entry_t       push_entry;
    logic            next_wren;
    logic [4:0]      next_waddr;
    logic [XLEN-1:0] next_wdata;

    assign pipe_pkg = bus.pipe_wb_pkg;
    assign div_pkg  = bus.div_wb_pkg;

    assign push_entry = '{rd_data: div_pkg.rd_data, rd_addr: div_pkg.rd_addr, valid: 1'b1};

    // The in-order writer is younger than anything the divider offers, so it
    // wins the port and kills both queued and same-cycle divider results to its rd.
    always_comb begin
        pipe_win   = writes_rd(pipe_pkg);
        div_ok     = writes_rd(div_pkg) & ~full;
        div_killed = pipe_win & (div_pkg.rd_addr == pipe_pkg.rd_addr);
        bypass     = div_ok & ~pipe_win & empty;
        push       = div_ok & ~div_killed & ~bypass;
        pop        = ~pipe_win & ~empty;

        next_wren  = 1'b0;
        next_waddr = pipe_pkg.rd_addr;
        next_wdata = pipe_pkg.rd_data;
        if (pipe_win) begin
            next_wren = 1'b1;
        end else if (pop) begin
            next_wren  = head.valid;
            next_waddr = head.rd_addr;
            next_wdata = head.rd_data;
        end else if (bypass) begin
            next_wren  = 1'b1;
            next_waddr = div_pkg.rd_addr;
            next_wdata = div_pkg.rd_data;
        end
    end

    wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (pipe_win),
        .kill_addr  (pipe_pkg.rd_addr),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .pend_mask  (bus.pend_mask)
    );

    assign bus.div_stall = full;

    register #(.WIDTH(1)) u_wren_reg (
        .clk (i_clk),
        .rst (i_rst),
        .en  (1'b1),
        .d   (next_wren),
        .q   (bus.rf_wren)
    );

    // Address and data only move on a real write so idle cycles keep the last values.
    register #(.WIDTH(5 + XLEN)) u_wdata_reg (
        .clk (i_clk),
        .rst (i_rst),
        .en  (next_wren),
        .d   ({next_waddr, next_wdata}),
        .q   ({bus.rf_waddr, bus.rf_wdata})
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(div_ok && pipe_pkg.wren && !pipe_pkg.valid &&
                      pipe_pkg.rd_addr == div_pkg.rd_addr));
        end
    end

endmodule
